// File: rtl/roulette_wheel.sv
// Spin-result generator for the roulette game: animates a counting display, then draws
// an unbiased 1..MAX_NUM value from a free-running Galois LFSR by rejection sampling.
module roulette_wheel #(
  parameter int          MAX_NUM      = 31,
  parameter int          SPIN_STEPS   = 24,
  parameter int          STEP_DIV     = 2500000,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spin,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        result_ack,
  output logic        spinning,
  output logic [4:0]  display_num,
  output logic        result_valid,
  output logic [4:0]  result,
  output logic        parity,
  output logic [7:0]  spin_count,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_lfsr
);

  // Handshake: result_valid rises when a value is drawn and stays high with result
  // stable until result_ack is sampled high; result_valid drops on the following cycle.

  localparam int DIV_W  = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
  localparam int STEP_W = (SPIN_STEPS > 1) ? $clog2(SPIN_STEPS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPIN_STEPS - 1);
  localparam logic [4:0]        MAX_5     = 5'(MAX_NUM);

  typedef enum logic [1:0] {IDLE, SPIN, SETTLE, HOLD} state_t;

  state_t              state, state_next;
  logic [15:0]         lfsr, lfsr_next;
  logic                spin_q, spin_edge;
  logic [DIV_W-1:0]    div_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                div_last, step_last;
  logic [4:0]          r;
  logic                r_ok;

  assign spin_edge = spin & ~spin_q;
  assign div_last  = (div_cnt == DIV_LAST);
  assign step_last = (step_cnt == STEP_LAST);
  assign r         = lfsr[4:0];
  assign r_ok      = (r != 5'd0) && (r <= MAX_5);
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign dbg_state = state;
  assign dbg_lfsr  = lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    spinning   = 1'b0;
    case (state)
      IDLE:   if (spin_edge) state_next = SPIN;
      SPIN: begin
        spinning = 1'b1;
        if (div_last && step_last) state_next = SETTLE;
      end
      SETTLE: begin
        spinning = 1'b1;
        if (r_ok) state_next = HOLD;
      end
      HOLD:   if (result_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= SEED_DEFAULT;
      spin_q       <= 1'b1;
      div_cnt      <= '0;
      step_cnt     <= '0;
      display_num  <= 5'd1;
      result_valid <= 1'b0;
      result       <= 5'd0;
      parity       <= 1'b0;
      spin_count   <= 8'd0;
    end else begin
      spin_q <= spin;
      // A zero seed would lock the LFSR at zero, so it is replaced by the default.
      if (state == IDLE && seed_load)
        lfsr <= (seed == 16'd0) ? SEED_DEFAULT : seed;
      else
        lfsr <= lfsr_next;

      case (state)
        IDLE: begin
          if (spin_edge) begin
            div_cnt  <= '0;
            step_cnt <= '0;
          end
        end
        SPIN: begin
          if (div_last) begin
            div_cnt     <= '0;
            step_cnt    <= step_cnt + STEP_W'(1);
            display_num <= (display_num >= MAX_5) ? 5'd1 : display_num + 5'd1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SETTLE: begin
          if (r_ok) begin
            result       <= r;
            display_num  <= r;
            parity       <= r[0];
            result_valid <= 1'b1;
            if (spin_count != 8'hFF) spin_count <= spin_count + 8'd1;
          end
        end
        HOLD: begin
          if (result_ack) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
